// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_if
// Description : Request/response bundle between operand read, the iterative
//               multiply/divide unit and register writeback.
// Revision    : 1.0
// ============================================================================
interface mdu_iter_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       src1;
    logic [XLEN-1:0]       src2;
    logic [ADDR_WIDTH-1:0] rd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic [XLEN-1:0]       out_data;
    logic                  busy;

    modport master (
        output in_valid, funct3, src1, src2, rd_in, out_ready,
        input  in_ready, out_valid, out_rd, out_data, busy
    );

    modport slave (
        input  in_valid, funct3, src1, src2, rd_in, out_ready,
        output in_ready, out_valid, out_rd, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply/divide unit (shift-add multiply,
//               restoring divide, one bit per cycle) feeding rd writeback.
// Revision    : 1.0
// ============================================================================
module mdu_iter #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    mdu_iter_if.slave  bus
);

    localparam int c_CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_neg;
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_opb;
    logic [XLEN-1:0]       r_res;

    // ---------------- accept-time decode ----------------
    logic            w_accept;
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div0, w_ovf, w_special, w_neg_flag;
    logic [XLEN-1:0] w_special_res;

    assign w_accept   = bus.in_valid && (r_state == S_IDLE) && !flush;
    assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                        (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                        (bus.funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && bus.src1[XLEN-1];
    assign w_b_neg    = w_b_signed && bus.src2[XLEN-1];
    assign w_a_mag    = w_a_neg ? -bus.src1 : bus.src1;
    assign w_b_mag    = w_b_neg ? -bus.src2 : bus.src2;

    // Remainder follows the dividend's sign; products and quotients the XOR.
    assign w_neg_flag = (bus.funct3[2] && bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div0    = bus.funct3[2] && (bus.src2 == '0);
    assign w_ovf     = bus.funct3[2] && !bus.funct3[0] &&
                       (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src2 == '1);
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (bus.funct3[1] ? bus.src1 : '1)
                                  : (bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_trial;
    logic              w_q_bit;
    logic [XLEN-1:0]   w_div_rem_next;

    assign w_mul_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : '0)};
    assign w_mul_next     = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_div_trial    = w_div_shift - {1'b0, r_opb};
    assign w_q_bit        = !w_div_trial[XLEN];
    assign w_div_rem_next = w_q_bit ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0];

    // ---------------- result fix-up ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_remv, w_fix_res;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_remv = r_neg ? -r_rem : r_rem;

    always_comb begin
        w_fix_res = w_remv;
        case (r_op)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_remv;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (w_accept) begin
                    if (!bus.funct3[2]) w_next = S_MUL;
                    else if (w_special) w_next = S_DONE;
                    else                w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == '0) w_next = S_FIX;
            end
            S_FIX:   w_next = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_rd  <= '0;
            r_neg <= 1'b0;
            r_acc <= '0;
            r_rem <= '0;
            r_opb <= '0;
            r_res <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.funct3;
                        r_rd  <= bus.rd_in;
                        r_neg <= w_neg_flag;
                        r_cnt <= c_CNT_W'(XLEN-1);
                        r_rem <= '0;
                        // Multiply iterates over b with a as addend; divide shifts a out against b.
                        r_opb <= bus.funct3[2] ? w_b_mag : w_a_mag;
                        r_acc <= {{XLEN{1'b0}}, (bus.funct3[2] ? w_a_mag : w_b_mag)};
                        if (w_special) r_res <= w_special_res;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                S_DIV: begin
                    r_rem            <= w_div_rem_next;
                    r_acc[XLEN-1:0]  <= {r_acc[XLEN-2:0], w_q_bit};
                    r_cnt            <= r_cnt - c_CNT_W'(1);
                end
                S_FIX:   r_res <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign bus.out_rd   = r_rd;
    assign bus.out_data = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Directed self-checking bench for mdu_iter with an arithmetic
//               reference model and a per-cycle output compare process.
// Revision    : 1.0
// ============================================================================
module tb_mdu_iter;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(32), .ADDR_WIDTH(5)) bus ();

    mdu_iter #(.XLEN(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics from 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (f[2] && b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        case (f)
            3'd0:    pr = 64'(sa * sb);
            3'd1:    pr = 64'(sa * sb) >> 32;
            3'd2:    pr = 64'(sa * ub) >> 32;
            3'd3:    pr = ({32'b0, a} * {32'b0, b}) >> 32;
            3'd4:    pr = 64'(sa / sb);
            3'd5:    pr = 64'(ua / ub);
            3'd6:    pr = 64'(sa % sb);
            default: pr = 64'(ua % ub);
        endcase
        return pr[31:0];
    endfunction

    // Compare process: checks every handoff against the model and holding during stalls.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_rd;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("ready_vs_busy", 32'(bus.in_ready), 32'(!bus.busy));
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_rd", 32'(bus.out_rd), 32'(prev_rd));
            end
            if (bus.out_valid && bus.out_ready && !flush) begin
                chk("result_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("model_data", bus.out_data, e.data);
                    chk("model_rd", 32'(bus.out_rd), 32'(e.rd));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !flush;
            prev_data  = bus.out_data;
            prev_rd    = bus.out_rd;
        end
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.src1     = a;
        bus.src2     = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
        bus.rd_in    = 5'($urandom);
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit,
                         input int exp_lat, input int hold);
        int   lat;
        logic ir_low;
        bus.out_ready = (hold == 0);
        issue(f, a, b, rd);
        q.push_back(exp_t'{rd: rd, data: model(f, a, b)});
        lat    = 1;
        ir_low = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.out_valid || lat >= 100) break;
            if (bus.in_ready) ir_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, bus.out_data, lit);
        chk({name, "_rd"}, 32'(bus.out_rd), 32'(rd));
        chk({name, "_in_ready_low"}, 32'(ir_low), 32'd1);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
        chk({name, "_valid_dropped"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'd0;
        bus.src1      = 32'd0;
        bus.src2      = 32'd0;
        bus.rd_in     = 5'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 0);
        do_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 32'h4000_0000, 34, 0);
        do_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34, 0);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4, 32'hFFFF_FFFF, 34, 0);
        do_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5, 32'hFFFF_FFFD, 34, 0);
        do_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6, 32'hFFFF_FFFF, 34, 0);
        do_op("divu",   3'd5, 32'd100,        32'd7,         5'd7, 32'd14,        34, 0);
        do_op("remu",   3'd7, 32'd100,        32'd7,         5'd8, 32'd2,         34, 0);
        do_op("div0",   3'd4, 32'd5,          32'd0,         5'd9, 32'hFFFF_FFFF, 1,  0);
        do_op("rem0",   3'd6, 32'd5,          32'd0,         5'd10, 32'd5,        1,  0);
        do_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0);
        do_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,        1,  0);
        do_op("mul_neg", 3'd0, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 5'd13, 32'd100,      34, 0);
        do_op("bp_rd0", 3'd5, 32'd100,        32'd7,         5'd0,  32'd14,       34, 10);

        // Flush mid-divide: result must never appear.
        bus.out_ready = 1'b1;
        issue(3'd4, 32'd1000, 32'd7, 5'd14);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        watch_quiet("flush_no_valid", 40);

        // Flush in IDLE blocks the request.
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.funct3   = 3'd0;
        bus.src1     = 32'd3;
        bus.src2     = 32'd3;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle_not_accepted", 32'(bus.busy), 32'd0);
        watch_quiet("flush_idle_no_valid", 40);

        // Flush in DONE together with out_ready: no handoff.
        bus.out_ready = 1'b0;
        issue(3'd4, 32'd5, 32'd0, 5'd15);
        chk("flush_done_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_done_dropped", 32'(bus.out_valid), 32'd0);
        chk("flush_done_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset mid-multiply.
        issue(3'd0, 32'd5, 32'd6, 5'd7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("mrst_out_data", bus.out_data, 32'd0);
        watch_quiet("mrst_no_valid", 40);
        do_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd16, 32'd12, 34, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit sitting between operand read and register writeback.
- Consumes rs1/rs2 values read from the general-purpose register file; after completion, produces the rd write request that drives the register file write port (wen/waddr/wdata).
- Used for all funct7=0000001 OP instructions; the core stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width
ADDR_WIDTH, 5, register index width (matches register file)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  abort current op, discard result
in_valid  in  1  operation request
in_ready  out  1  unit can accept (IDLE only)
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  in  XLEN  rs1 value
src2  in  XLEN  rs2 value
rd_in  in  ADDR_WIDTH  destination index
out_valid  out  1  result available
out_ready  in  1  writeback accepts result
out_rd  out  ADDR_WIDTH  destination index (to register file waddr)
out_data  out  XLEN  result (to register file wdata)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; busy=0; out_rd=0; out_data=0.
  - Counter=0 and all datapath registers are cleared.
  - rst has priority over flush and over every handshake.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept:
  - Happens on the posedge where in_valid && in_ready.
  - funct3, rd_in and operands are latched at that edge.
  - Later changes on the inputs are ignored.
- IDLE transitions after accept:
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 with src2==0 goes directly to DONE.
    - DIV/DIVU result = all-ones.
    - REM/REMU result = src1.
  - DIV/REM with src1==0x80000000 and src2==0xFFFFFFFF goes directly to DONE.
    - DIV result = 0x80000000.
    - REM result = 0.
  - Otherwise goes to DIV.
- Signedness and magnitudes:
  - Operand a is signed for MULH, MULHSU, DIV and REM.
  - Operand b is signed for MULH, DIV and REM.
  - Signed operands are converted to magnitudes before iterating.
  - The result-negate flag is recorded at accept.
    - Multiply product and quotient: negate if the operand signs differ.
    - Remainder: negate if the dividend is negative.
- MUL state:
  - Shift-add: exactly XLEN cycles, one multiplier bit per cycle.
  - 2*XLEN-bit accumulator.
- DIV state:
  - Restoring division: exactly XLEN cycles, one quotient bit per cycle.
  - XLEN+1-bit partial remainder.
- Counter:
  - Loaded with XLEN-1 on entering MUL or DIV.
  - Decrements every cycle; the transition to FIX happens when counter==0.
- FIX state (1 cycle):
  - Applies two's-complement negation if flagged.
  - Selects the result:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Goes to DONE.
- Latency:
  - Normal ops: out_valid is first high XLEN+2 cycles after the accept edge (34 for XLEN=32).
  - Special cases: out_valid is high 1 cycle after the accept edge.
- DONE state:
  - out_valid=1; out_rd and out_data are stable and held until out_ready.
  - On the posedge with out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
  - No back-to-back accept in the same cycle as a handoff; in_ready rises the cycle after.
- rd_in==0: the op is computed normally and out_rd=0. The register file drops the write.
- flush=1 at posedge (rst=0):
  - Any state goes to IDLE; out_valid=0 from the next cycle; the result is never presented.
  - flush with in_valid in IDLE: the request is not accepted.
  - flush in DONE with out_ready in the same cycle: the handshake is ignored and no write occurs.
- busy is high in MUL, DIV, FIX and DONE.
- The writeback stage asserts the register-file write enable only for out_valid && out_ready.

Test Plan:
- MUL 7 × -3 (src2=0xFFFFFFFD), out_ready=1 → out_data=0xFFFFFFEB; out_valid at accept+34; in_ready low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0x2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; overflow DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; each with out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, out_rd and out_data stable; raise out_ready → one handoff, in_ready=1 the next cycle.
- flush at cycle 10 of a DIV, then rst during a MUL → IDLE next cycle, out_valid never asserted, all outputs zero after rst, next op (MUL 3×4=12) correct.
